// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//
// Word-organised data RAM behind a valid/ready request/response handshake,
// used as the data memory of a CPU test harness. One request is outstanding
// at a time: a request is taken in IDLE, its response is presented in RESP
// until the CPU consumes it, then the responder returns to IDLE.
//
// Stores to STATUS_ADDR are also watched as an end-of-test mailbox: the first
// good store there raises the sticky done flag and latches whether the stored
// value equals PASS_VALUE.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active low
//   req_valid    in   request present
//   req_ready    out  request can be taken this cycle (state is IDLE)
//   req_we       in   1 = store, 0 = load
//   req_addr     in   byte address
//   req_wdata    in   store data
//   req_be       in   store byte enables, bit i -> byte lane i
//   rsp_valid    out  response present
//   rsp_ready    in   response consumed
//   rsp_rdata    out  load data (0 for stores and errored requests)
//   rsp_err      out  request was misaligned or out of range
//   done         out  sticky, a good store hit STATUS_ADDR
//   pass         out  sticky, first status store carried PASS_VALUE
//   store_count  out  number of good stores, saturating
// ----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] STATUS_ADDR = 32'd100,
    parameter logic [31:0] PASS_VALUE  = 32'd25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        done,
    output logic        pass,
    output logic [15:0] store_count
);

    localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t            state;
    logic [31:0]       mem [DEPTH_WORDS];

    logic              acc_p0;
    logic              err_p0;
    logic              wr_p0;
    logic              status_hit_p0;
    logic [IDX_W-1:0]  idx_p0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ---- Stage p0: request decode (combinational, acceptance cycle) ----
    assign req_ready     = (state == IDLE);
    assign acc_p0        = req_valid & req_ready;
    assign err_p0        = (req_addr[1:0] != 2'b00) || (req_addr >= ADDR_LIMIT);
    assign idx_p0        = req_addr[IDX_W+1:2];
    assign wr_p0         = acc_p0 & req_we & ~err_p0;
    assign status_hit_p0 = wr_p0 & (req_addr == STATUS_ADDR);

    // RAM has no reset; the write is held off while reset is asserted because
    // req_ready reads 1 during reset and must not let a request slip in.
    always_ff @(posedge clk) begin
        if (rst && wr_p0) begin
            for (int i = 0; i < 4; i++) begin
                if (req_be[i]) begin
                    mem[idx_p0][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // ---- Stage p1: response / status registers ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'd0;
            rsp_err     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            store_count <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc_p0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= err_p0;
                        // Loads see the word as it stands at the acceptance
                        // edge; a preceding store has already landed.
                        rsp_rdata <= (err_p0 || req_we) ? 32'd0 : mem[idx_p0];
                        if (wr_p0) begin
                            store_count <= sat_inc16(store_count);
                        end
                        // Only the first status store decides the verdict.
                        if (status_hit_p0 && !done) begin
                            done <= 1'b1;
                            pass <= (req_wdata == PASS_VALUE);
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Transaction-level reference model of the data memory responder (byte array
// with per-byte "written" tracking, pending-response flag, counters) checked
// against the DUT every falling clock edge, plus directed scenarios with
// hand-computed literal expectations and a randomized request phase.
// ----------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int          DEPTH  = 64;
    localparam logic [31:0] STATUS = 32'd100;
    localparam logic [31:0] PASSV  = 32'd25;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        done;
    logic        pass;
    logic [15:0] store_count;

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .STATUS_ADDR (STATUS),
        .PASS_VALUE  (PASSV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_be      (req_be),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .done        (done),
        .pass        (pass),
        .store_count (store_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem [DEPTH];
    logic [3:0]  m_kb  [DEPTH];   // bytes that have ever been written
    bit          m_pend;
    bit          m_err;
    logic [31:0] m_rd;
    logic [31:0] m_mask;          // bytes of m_rd that are defined
    int          m_cnt;
    bit          m_done;
    bit          m_pass;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = 32'd0;
            m_kb[i]  = 4'd0;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pend = 1'b0;
            m_err  = 1'b0;
            m_rd   = 32'd0;
            m_mask = 32'hFFFF_FFFF;
            m_cnt  = 0;
            m_done = 1'b0;
            m_pass = 1'b0;
        end else if (!m_pend) begin
            if (req_valid) begin
                int  w;
                bit  bad;
                bad    = (req_addr % 4 != 0) || (req_addr >= 32'(4 * DEPTH));
                w      = int'(req_addr / 4);
                m_pend = 1'b1;
                m_err  = bad;
                m_rd   = 32'd0;
                m_mask = 32'hFFFF_FFFF;
                if (!bad && !req_we) begin
                    m_rd   = m_mem[w];
                    m_mask = 32'd0;
                    for (int b = 0; b < 4; b++)
                        if (m_kb[w][b]) m_mask[8*b +: 8] = 8'hFF;
                end
                if (!bad && req_we) begin
                    for (int b = 0; b < 4; b++)
                        if (req_be[b]) begin
                            m_mem[w][8*b +: 8] = req_wdata[8*b +: 8];
                            m_kb[w][b]         = 1'b1;
                        end
                    if (m_cnt < 65535) m_cnt = m_cnt + 1;
                    if (req_addr == STATUS && !m_done) begin
                        m_done = 1'b1;
                        m_pass = (req_wdata == PASSV);
                    end
                end
            end
        end else if (rsp_ready) begin
            m_pend = 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(!m_pend));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_pend));
            if (m_pend) begin
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
                if (m_mask != 32'd0)
                    chk("rsp_rdata", rsp_rdata & m_mask, m_rd & m_mask);
            end
            chk("store_count", 32'(store_count), 32'(m_cnt));
            chk("done", 32'(done), 32'(m_done));
            if (m_done) chk("pass", 32'(pass), 32'(m_pass));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic junk_inputs();
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = 32'($urandom_range(0, 255));
        req_wdata = $urandom;
        req_be    = 4'($urandom_range(0, 15));
    endtask

    // Called at posedge+1; reset asserted mid-cycle, released at next posedge+1.
    task automatic do_reset();
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_store_count", 32'(store_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // One full transaction; entered and left at posedge+1.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input int hold,
                         output logic [31:0] rd, output logic er,
                         output logic dn1, output logic ps1);
        int waitc;
        waitc     = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        rsp_ready = 1'b0;
        while (!req_ready && waitc < 20) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        chk("issue_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        junk_inputs();
        chk("rsp_latency1", 32'(rsp_valid), 32'd1);
        dn1 = done;
        ps1 = pass;
        repeat (hold) begin
            @(posedge clk);
            #1;
            junk_inputs();
        end
        rd        = rsp_rdata;
        er        = rsp_err;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 5)      return 32'($urandom_range(0, 15)) * 4;
        else if (r == 6) return STATUS;
        else if (r == 7) return 32'($urandom_range(0, 255)) | 32'd1;
        else if (r == 8) return 32'd256 + 32'($urandom_range(0, 100)) * 4;
        else             return $urandom & 32'hFFFF_FFFC;
    endfunction

    // ---------------- main sequence ----------------
    logic [31:0] rd;
    logic        er, dn, ps;

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_be    = 4'd0;
        rsp_ready = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        chk_en = 1'b1;
        chk("init_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("init_req_ready", 32'(req_ready), 32'd1);
        chk("init_store_count", 32'(store_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // store then load the same word
        issue(1'b1, 32'd96, 32'hDEADBEEF, 4'hF, 0, rd, er, dn, ps);
        chk("st96_err", 32'(er), 32'd0);
        issue(1'b0, 32'd96, 32'd0, 4'h0, 0, rd, er, dn, ps);
        chk("ld96_rdata", rd, 32'hDEADBEEF);
        chk("ld96_err", 32'(er), 32'd0);
        chk("ld96_count", 32'(store_count), 32'd1);
        chk("ld96_done", 32'(done), 32'd0);

        // passing status store, then a later one that must not change the verdict
        do_reset();
        issue(1'b1, 32'd100, 32'd25, 4'hF, 1, rd, er, dn, ps);
        chk("st25_done_next", 32'(dn), 32'd1);
        chk("st25_pass_next", 32'(ps), 32'd1);
        issue(1'b1, 32'd100, 32'd7, 4'hF, 0, rd, er, dn, ps);
        chk("st7_done", 32'(done), 32'd1);
        chk("st7_pass", 32'(pass), 32'd1);
        chk("st7_count", 32'(store_count), 32'd2);

        // failing status store
        do_reset();
        issue(1'b1, 32'd100, 32'd24, 4'h0, 2, rd, er, dn, ps);
        chk("st24_done", 32'(done), 32'd1);
        chk("st24_pass", 32'(pass), 32'd0);

        // errored stores leave RAM and counters alone; RAM survives reset
        do_reset();
        issue(1'b1, 32'd100, 32'h5A5A5A5A, 4'hF, 0, rd, er, dn, ps);
        do_reset();
        issue(1'b1, 32'd102, 32'h01010101, 4'hF, 0, rd, er, dn, ps);
        chk("st102_err", 32'(er), 32'd1);
        chk("st102_rdata", rd, 32'd0);
        issue(1'b1, 32'd256, 32'h02020202, 4'hF, 0, rd, er, dn, ps);
        chk("st256_err", 32'(er), 32'd1);
        chk("err_count", 32'(store_count), 32'd0);
        chk("err_done", 32'(done), 32'd0);
        issue(1'b0, 32'd100, 32'd0, 4'h0, 0, rd, er, dn, ps);
        chk("w25_unchanged", rd, 32'h5A5A5A5A);
        issue(1'b0, 32'd3, 32'd0, 4'h0, 0, rd, er, dn, ps);
        chk("ld3_err", 32'(er), 32'd1);
        chk("ld3_rdata", rd, 32'd0);

        // byte lanes
        do_reset();
        issue(1'b1, 32'd0, 32'h11223344, 4'hF, 0, rd, er, dn, ps);
        issue(1'b1, 32'd0, 32'hAABBCCDD, 4'b0101, 0, rd, er, dn, ps);
        issue(1'b1, 32'd0, 32'hFFFFFFFF, 4'b0000, 0, rd, er, dn, ps);
        issue(1'b0, 32'd0, 32'd0, 4'h0, 0, rd, er, dn, ps);
        chk("lane_merge", rd, 32'h11BB33DD);
        chk("lane_count", 32'(store_count), 32'd3);

        // held response, then reset in the middle of it
        do_reset();
        issue(1'b1, 32'd100, 32'd25, 4'hF, 0, rd, er, dn, ps);
        issue(1'b1, 32'd8, 32'hCAFEF00D, 4'hF, 0, rd, er, dn, ps);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'd8;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_count", 32'(store_count), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("postrst_no_rsp", 32'(rsp_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b0;

        // randomized traffic, one asynchronous reset in the middle
        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                req_valid = 1'b0;
                #1;
                rst = 1'b0;
                #1;
                chk("rnd_rst_rsp_valid", 32'(rsp_valid), 32'd0);
                @(posedge clk);
                #1;
                rst = 1'b1;
            end
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = rnd_addr();
            req_wdata = ($urandom_range(0, 3) == 0) ? PASSV : $urandom;
            req_be    = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end

        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("drain_rsp_valid", 32'(rsp_valid), 32'd0);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter: DEPTH_WORDS, 64, number of 32-bit RAM words, byte addresses 0 .. 4*DEPTH_WORDS-1.
REQ-002 Parameter: STATUS_ADDR, 32'd100, word-aligned byte address whose stores are monitored as end-of-test status.
REQ-003 Parameter: PASS_VALUE, 32'd25, store data at STATUS_ADDR meaning test passed.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 Port: req_valid  input  1  CPU memory request present.
REQ-007 Port: req_ready  output  1  responder accepts a request this cycle.
REQ-008 Port: req_we  input  1  1 = store, 0 = load.
REQ-009 Port: req_addr  input  32  byte address (ALUResultM from the core).
REQ-010 Port: req_wdata  input  32  store data (WriteDataM from the core).
REQ-011 Port: req_be  input  4  byte enables for stores; bit i writes byte lane i.
REQ-012 Port: rsp_valid  output  1  response available.
REQ-013 Port: rsp_ready  input  1  CPU consumes response.
REQ-014 Port: rsp_rdata  output  32  load data; 0 for stores and errored requests.
REQ-015 Port: rsp_err  output  1  request was misaligned or out of range.
REQ-016 Port: done  output  1  sticky; a store hit STATUS_ADDR.
REQ-017 Port: pass  output  1  sticky; valid when done=1; 1 if first status store carried PASS_VALUE.
REQ-018 Port: store_count  output  16  number of successful stores, saturating at 16'hFFFF.

Function
REQ-019 FSM states IDLE and RESP; req_ready SHALL equal (state==IDLE).
REQ-020 Request accepted on req_valid & req_ready; IDLE -> RESP on acceptance.
REQ-021 RESP: rsp_valid=1; rsp_rdata/rsp_err held stable until rsp_ready=1; RESP -> IDLE on rsp_valid & rsp_ready.
REQ-022 One outstanding request max; every request (load or store) receives exactly one response; minimum latency 1 cycle (rsp_valid the cycle after acceptance).
REQ-023 Back-to-back: after RESP -> IDLE, next request accepted in following cycle (throughput 1 per 2 cycles).
REQ-024 Error = req_addr[1:0]!=0 or req_addr >= 4*DEPTH_WORDS; errored request: rsp_err=1, rsp_rdata=0, no RAM write, no count, no status update.
REQ-025 Store (no error): RAM word req_addr[.. :2] updated at acceptance edge, only lanes with req_be[i]=1; req_be=0 is a legal no-op write but still counted.
REQ-026 Load (no error): rsp_rdata = RAM word contents at acceptance edge; a load directly following a store to the same word returns the new data.
REQ-027 store_count increments by 1 per accepted non-errored store; holds at 16'hFFFF.
REQ-028 First accepted non-errored store with req_addr==STATUS_ADDR: done<=1, pass<=(req_wdata==PASS_VALUE); req_be ignored for comparison.
REQ-029 done/pass sticky: later status stores update RAM and count but never change done/pass.
REQ-030 RAM contents are not reset; loads of never-written words return undefined data.
REQ-031 Request inputs ignored when req_ready=0.

Reset
REQ-032 rst=0 asynchronously forces: state=IDLE, req_ready=1 once released, rsp_valid=0, rsp_rdata=0, rsp_err=0, done=0, pass=0, store_count=0.
REQ-033 Reset during RESP discards the pending response; no response issued after release.
REQ-034 Reset released synchronously to clk by the system; first request may be accepted on the first rising edge with rst=1.

Verification
REQ-035 Store 32'hDEADBEEF to addr 96 be=4'hF, then load addr 96 -> load rsp_rdata=32'hDEADBEEF, rsp_err=0, store_count=1, done=0.
REQ-036 Store 32'd25 to addr 100 -> done=1, pass=1 in cycle after acceptance; then store 32'd7 to addr 100 -> done=1, pass=1 unchanged, store_count=2.
REQ-037 Fresh reset, store 32'd24 to addr 100 -> done=1, pass=0.
REQ-038 Store to addr 102 and to addr 256 -> rsp_err=1 each, store_count=0, RAM word 25 unchanged.
REQ-039 Store 32'h11223344 be=4'hF to addr 0, then 32'hAABBCCDD be=4'b0101 to addr 0, load addr 0 -> 32'h11BB33DD.
REQ-040 Hold rsp_ready=0 for 3 cycles during RESP -> rsp_valid/rsp_rdata stable, req_ready=0; assert rst=0 mid-RESP -> rsp_valid=0 immediately, done=0, store_count=0.
